fxpsm_matmul_array: RTL and testbench

- Parametrised successor to the fixed 3x3 8-bit sign-magnitude PE array: computes C = A x B for two NxN sign-magnitude fixed-point matrices.
- Operands are loaded over one valid/ready input stream, with zero-padding of short rows and matrices.
- Accumulates one k-step per cycle across an NxN accumulator grid, then drains C row-major over a valid/ready output stream with saturation.
- Sits between the operand streamer and the result writer in the fixed-point datapath.

---
 rtl/fxpsm_matmul_array.sv | 241 ++++++++++++++++++++++++
 tb/tb_fxpsm_matmul_array.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxpsm_matmul_array.sv
// fxpsm_matmul_array
//   Computes C = A x B for two NxN sign-magnitude fixed-point matrices.
//   Operands arrive over one valid/ready stream (A and B beats may
//   interleave). Short rows and matrices are zero-padded. One k-step is
//   accumulated per cycle over an NxN grid of two's-complement
//   accumulators. C is then drained row-major, with saturation, over a
//   valid/ready output stream.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid      input beat valid
//   in_ready      input beat accepted when in_valid & in_ready
//   in_mat        target matrix (0 = A, 1 = B)
//   in_new_row    beat is element 0 of a new row (pads the current row first)
//   in_mat_done   marker beat, pads the rest of the matrix; in_data ignored
//   in_data       sign-magnitude element
//   out_valid     output beat valid
//   out_ready     output beat consumed when out_valid & out_ready
//   out_new_row   beat is column 0 of a row of C
//   out_last      beat is C[N-1][N-1]
//   out_data      sign-magnitude element of C
//   busy          high while computing or draining
//   sat_flag      sticky: some C element of the current/last operation saturated
module fxpsm_matmul_array #(
    parameter int N     = 3,
    parameter int W     = 8,
    parameter int FRAC  = 3,
    parameter int ACC_W = 2*W+4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mat,
    input  logic         in_new_row,
    input  logic         in_mat_done,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_new_row,
    output logic         out_last,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         sat_flag
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]    LASTI = CW'(N-1);
    localparam logic [ACC_W-1:0] MAXM  = ACC_W'((1 << (W-1)) - 1);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [W-1:0]             a_buf [N][N];
    logic [W-1:0]             b_buf [N][N];
    logic signed [ACC_W-1:0]  acc   [N][N];

    logic [CW-1:0] a_row, a_col, b_row, b_col;
    logic          a_loaded, b_loaded;
    // pend: matrix completed by in_mat_done padding, marker not yet consumed
    logic          a_pend, b_pend;
    logic [CW-1:0] kc, oi, oj;

    logic [CW-1:0] a_row_n, a_col_n, b_row_n, b_col_n;
    logic          a_loaded_n, b_loaded_n, a_pend_n, b_pend_n;

    logic [CW-1:0] sel_row, sel_col, col_adv, row_adv;
    logic          sel_loaded, sel_pend, sel_end;
    logic          ready_c, pad, wr_en, consume;
    logic [W-1:0]  wr_data;
    logic          out_hs, clear;

    logic signed [ACC_W-1:0] cur_acc;
    logic [ACC_W-1:0]        acc_mag;
    logic                    conv_sat;
    logic [W-1:0]            conv_data;

    // Sign-magnitude product, truncated to FRAC, as a signed accumulator term.
    // A zero magnitude yields 0 whatever the signs, so -0 never leaks in.
    function automatic logic signed [ACC_W-1:0] sm_prod(input logic [W-1:0] x,
                                                        input logic [W-1:0] y);
        logic [2*W-3:0]          p;
        logic signed [ACC_W-1:0] e;
        p = ({{(W-1){1'b0}}, x[W-2:0]} * {{(W-1){1'b0}}, y[W-2:0]}) >> FRAC;
        e = ACC_W'(p);
        sm_prod = (x[W-1] ^ y[W-1]) ? -e : e;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    // Load bookkeeping and next state. in_ready is a function of state,
    // in_mat, flags and the addressed counters only, never of in_valid.
    always_comb begin
        a_row_n    = a_row;
        a_col_n    = a_col;
        b_row_n    = b_row;
        b_col_n    = b_col;
        a_loaded_n = a_loaded;
        b_loaded_n = b_loaded;
        a_pend_n   = a_pend;
        b_pend_n   = b_pend;
        ready_c    = 1'b0;
        pad        = 1'b0;
        wr_en      = 1'b0;
        consume    = 1'b0;
        wr_data    = in_data;
        state_nxt  = state;

        sel_row    = in_mat ? b_row    : a_row;
        sel_col    = in_mat ? b_col    : a_col;
        sel_loaded = in_mat ? b_loaded : a_loaded;
        sel_pend   = in_mat ? b_pend   : a_pend;
        sel_end    = (sel_row == LASTI) && (sel_col == LASTI);
        col_adv    = (sel_col == LASTI) ? '0 : sel_col + 1'b1;
        row_adv    = (sel_col == LASTI) ? (sel_end ? '0 : sel_row + 1'b1) : sel_row;

        if (state == S_LOAD) begin
            if (in_mat_done) ready_c = sel_pend;
            else             ready_c = !sel_loaded && (!in_new_row || sel_col == '0);
            pad     = in_valid && !sel_loaded &&
                      (in_mat_done || (in_new_row && sel_col != '0));
            wr_en   = pad || (in_valid && ready_c && !in_mat_done);
            consume = in_valid && ready_c && in_mat_done;
            if (pad) wr_data = '0;
        end

        if (wr_en) begin
            if (in_mat) begin
                b_col_n = col_adv;
                b_row_n = row_adv;
                if (sel_end) begin
                    b_loaded_n = 1'b1;
                    if (pad && in_mat_done) b_pend_n = 1'b1;
                end
            end else begin
                a_col_n = col_adv;
                a_row_n = row_adv;
                if (sel_end) begin
                    a_loaded_n = 1'b1;
                    if (pad && in_mat_done) a_pend_n = 1'b1;
                end
            end
        end
        if (consume) begin
            if (in_mat) b_pend_n = 1'b0;
            else        a_pend_n = 1'b0;
        end

        case (state)
            S_LOAD:    if (a_loaded_n && b_loaded_n && !a_pend_n && !b_pend_n)
                           state_nxt = S_COMPUTE;
            S_COMPUTE: if (kc == LASTI) state_nxt = S_DRAIN;
            S_DRAIN:   if (out_hs && out_last) state_nxt = S_LOAD;
            default:   state_nxt = S_LOAD;
        endcase
    end

    assign in_ready = ready_c && !rst;

    // Output conversion: saturate magnitude, keep sign, zero always as +0.
    always_comb begin
        cur_acc   = acc[oi][oj];
        acc_mag   = cur_acc[ACC_W-1] ? -cur_acc : cur_acc;
        conv_sat  = acc_mag > MAXM;
        conv_data = {cur_acc[ACC_W-1], conv_sat ? {(W-1){1'b1}} : acc_mag[W-2:0]};
        if (acc_mag == '0) conv_data = '0;
    end

    assign out_valid   = (state == S_DRAIN);
    assign out_data    = out_valid ? conv_data : '0;
    assign out_new_row = out_valid && (oj == '0);
    assign out_last    = out_valid && (oi == LASTI) && (oj == LASTI);
    assign busy        = (state != S_LOAD);
    assign out_hs      = out_valid && out_ready;
    assign clear       = out_hs && out_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    a_buf[i][j] <= '0;
                    b_buf[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
            a_row    <= '0;
            a_col    <= '0;
            b_row    <= '0;
            b_col    <= '0;
            a_loaded <= 1'b0;
            b_loaded <= 1'b0;
            a_pend   <= 1'b0;
            b_pend   <= 1'b0;
            kc       <= '0;
            oi       <= '0;
            oj       <= '0;
        end else begin
            a_row    <= a_row_n;
            a_col    <= a_col_n;
            b_row    <= b_row_n;
            b_col    <= b_col_n;
            a_loaded <= a_loaded_n;
            b_loaded <= b_loaded_n;
            a_pend   <= a_pend_n;
            b_pend   <= b_pend_n;

            if (wr_en) begin
                if (in_mat) b_buf[sel_row][sel_col] <= wr_data;
                else        a_buf[sel_row][sel_col] <= wr_data;
            end

            if (state == S_COMPUTE) begin
                for (int unsigned i = 0; i < N; i++) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        acc[i][j] <= acc[i][j] + sm_prod(a_buf[i][kc], b_buf[kc][j]);
                    end
                end
                kc <= (kc == LASTI) ? '0 : kc + 1'b1;
            end

            if (out_hs) begin
                if (oj == LASTI) begin
                    oj <= '0;
                    oi <= oi + 1'b1;
                end else begin
                    oj <= oj + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                       sat_flag <= 1'b0;
        else if (in_valid && in_ready) sat_flag <= 1'b0;
        else if (out_hs && conv_sat)   sat_flag <= 1'b1;
    end

endmodule

// File: tb/tb_fxpsm_matmul_array.sv
module tb_fxpsm_matmul_array;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int FRAC = 3;
    localparam int MAXM = (1 << (W-1)) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_mat, in_new_row, in_mat_done;
    logic [W-1:0] in_data;
    logic         out_valid, out_ready, out_new_row, out_last;
    logic [W-1:0] out_data;
    logic         busy, sat_flag;

    fxpsm_matmul_array #(.N(N), .W(W), .FRAC(FRAC), .ACC_W(2*W+4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
        .in_new_row(in_new_row), .in_mat_done(in_mat_done), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_new_row(out_new_row),
        .out_last(out_last), .out_data(out_data), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         nr;
        logic         last;
    } beat_t;

    beat_t sbq[$];
    int    am [N][N];
    int    bm [N][N];
    int    total = 0;
    int    bad   = 0;
    bit    exp_sat;

    function automatic int prod(int a, int b);
        int ma, mb, p;
        ma = a & MAXM;
        mb = b & MAXM;
        p  = (ma * mb) >> FRAC;
        return ((((a >> (W-1)) ^ (b >> (W-1))) & 1) != 0) ? -p : p;
    endfunction

    function automatic logic [W-1:0] to_sm(int v);
        int m;
        logic [W-1:0] r;
        m = (v < 0) ? -v : v;
        if (m > MAXM) m = MAXM;
        if (m == 0) return '0;
        r = W'(m);
        r[W-1] = (v < 0);
        return r;
    endfunction

    task automatic push_expected();
        int s;
        exp_sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += prod(am[i][k], bm[k][j]);
                if (s > MAXM || s < -MAXM) exp_sat = 1'b1;
                sbq.push_back({to_sm(s), (j == 0), (i == N-1 && j == N-1)});
            end
        end
    endtask

    task automatic send(input logic mat, input logic nr, input logic done, input logic [W-1:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_mat = mat; in_new_row = nr; in_mat_done = done; in_data = d;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%0b required 1 (mat=%0b)", in_ready, mat);
        end
        @(posedge clk);
    endtask

    task automatic send_full(input logic mat);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                send(mat, (j == 0), 1'b0, W'(mat ? bm[i][j] : am[i][j]));
    endtask

    task automatic drain(input bit rnd, input bit bpress);
        beat_t        e;
        logic [W-1:0] hd;
        logic         hnr, hl;
        bit           stall;
        int           cyc;
        stall = 0; cyc = 0; hd = '0; hnr = 0; hl = 0;
        while (sbq.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bpress) begin
                in_valid = 1'b1; in_mat = 1'b1; in_new_row = 1'b1; in_mat_done = 1'b0; in_data = 8'h33;
            end
            #1;
            if (bpress && busy) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_in_ready: got %0b required 0", in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                if (stall) begin
                    total++;
                    if ({out_data, out_new_row, out_last} !== {hd, hnr, hl}) begin
                        bad++;
                        $display("FAIL stall_stable: got %h/%0b/%0b required %h/%0b/%0b",
                                 out_data, out_new_row, out_last, hd, hnr, hl);
                    end
                end
                if (out_ready) begin
                    e = sbq.pop_front();
                    total++;
                    if ({out_data, out_new_row, out_last} !== {e.d, e.nr, e.last}) begin
                        bad++;
                        $display("FAIL beat: got data=%h nr=%0b last=%0b required data=%h nr=%0b last=%0b",
                                 out_data, out_new_row, out_last, e.d, e.nr, e.last);
                    end
                    if (e.last) in_valid = 1'b0;
                    stall = 0;
                end else begin
                    stall = 1; hd = out_data; hnr = out_new_row; hl = out_last;
                end
            end
        end
        if (sbq.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d beats missing, required 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_state: out_valid=%0b busy=%0b required 0/0", out_valid, busy);
        end
    endtask

    task automatic check_sat(input string nm, input logic req);
        total++;
        if (sat_flag !== req) begin
            bad++;
            $display("FAIL %s: sat_flag=%0b required %0b", nm, sat_flag, req);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_mat = 1'b0; in_new_row = 1'b0; in_mat_done = 1'b0;
        in_data = 8'h11; out_ready = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, out_new_row, out_last, out_data, busy, sat_flag} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: v=%0b nr=%0b l=%0b d=%h busy=%0b sat=%0b required all 0",
                     out_valid, out_new_row, out_last, out_data, busy, sat_flag);
        end
    endtask

    task automatic test_identity();
        logic [W-1:0] bv [9] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h88};
        int n;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = (i == j) ? 8'h08 : 8'h00;
                bm[i][j] = bv[i*N + j];
            end
        push_expected();
        send_full(1'b0);
        send_full(1'b1);
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (!out_valid && n < 20);
        total++;
        if (n != 4) begin
            bad++; $display("FAIL first_valid_latency: got %0d required 4", n);
        end
        drain(0, 0);
        check_sat("identity_sat", 1'b0);
    endtask

    task automatic test_padding();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 0;
                bm[i][j] = 8'h08;
            end
        am[0][0] = 8'h08; am[0][1] = 8'h10;
        am[1][0] = 8'h0C; am[1][1] = 8'h84;
        push_expected();
        send(1'b1, 1'b1, 1'b0, 8'h08);
        send(1'b0, 1'b1, 1'b0, 8'h08);
        send(1'b0, 1'b0, 1'b0, 8'h10);
        for (int k = 1; k < 5; k++) send(1'b1, (k % N) == 0, 1'b0, 8'h08);
        send(1'b0, 1'b1, 1'b0, 8'h0C);
        send(1'b0, 1'b0, 1'b0, 8'h84);
        send(1'b0, 1'b0, 1'b1, 8'h55);
        for (int k = 5; k < 9; k++) send(1'b1, (k % N) == 0, 1'b0, 8'h08);
        drain(0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 8'h7F;
                bm[i][j] = 8'h7F;
            end
        push_expected();
        send_full(1'b0);
        send_full(1'b1);
        drain(0, 0);
        check_sat("sat_positive", exp_sat);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) am[i][j] = 8'hFF;
        push_expected();
        send(1'b0, 1'b1, 1'b0, 8'hFF);
        #1;
        check_sat("sat_cleared_on_beat", 1'b0);
        for (int k = 1; k < N*N; k++) send(1'b0, (k % N) == 0, 1'b0, 8'hFF);
        send_full(1'b1);
        drain(1, 0);
        check_sat("sat_negative", exp_sat);
    endtask

    task automatic test_negative_diag();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = (i == j) ? 8'h88 : 8'h80;
                bm[i][j] = (i == j) ? 8'h10 : 8'h00;
            end
        push_expected();
        send_full(1'b1);
        send_full(1'b0);
        drain(0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = int'($urandom_range(0, 255));
                bm[i][j] = int'($urandom_range(0, 255));
            end
        push_expected();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                send(1'b0, (j == 0), 1'b0, W'(am[i][j]));
                send(1'b1, (j == 0), 1'b0, W'(bm[i][j]));
            end
        drain(1, 1);
    endtask

    task automatic test_reset_mid_drain();
        beat_t e;
        int got, cyc;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 8'h7F;
                bm[i][j] = 8'h7F;
            end
        push_expected();
        send_full(1'b0);
        send_full(1'b1);
        got = 0; cyc = 0;
        while (got < 2 && cyc < 50) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1; cyc++;
            #1;
            if (out_valid) begin
                e = sbq.pop_front();
                total++;
                if (out_data !== e.d) begin
                    bad++; $display("FAIL pre_reset_beat: got %h required %h", out_data, e.d);
                end
                got++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check_sat("pre_reset_sat", 1'b1);
        sbq.delete();
        test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL stale_after_reset: out_valid=%0b required 0", out_valid);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                am[i][j] = 8'h04 + i;
                bm[i][j] = (j == 1) ? 8'h90 : 8'h18;
            end
        push_expected();
        send_full(1'b0);
        send_full(1'b1);
        drain(0, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mat = 1'b0; in_new_row = 1'b0;
        in_mat_done = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_identity();
        test_padding();
        test_saturation();
        test_negative_diag();
        test_back_to_back();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
